// File: rtl/mr_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding
// and watchdog counter width.
package mr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/mr_arb_watchdog.sv
// Stall watchdog: counts stalled strobe cycles and flags the cycle on which
// the TIMEOUT-th consecutive stall occurs.
module mr_arb_watchdog
    import mr_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count;

    // count holds the number of earlier stalls, so the current stall is the
    // TIMEOUT-th one when count has reached TIMEOUT-1.
    assign expired = en && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/mr_bus_arb.sv
// Round-robin arbiter granting one of two Wishbone masters (instruction
// fetch, load-store) access to a shared slave, with a stall watchdog.
`ifndef XLEN
`define XLEN 32
`endif

module mr_bus_arb
    import mr_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned XLEN    = `XLEN
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [XLEN-1:0]   wbm0_adr_i,
    input  logic [XLEN-1:0]   wbm0_dat_i,
    input  logic [XLEN/8-1:0] wbm0_sel_i,
    input  logic              wbm0_we_i,
    input  logic              wbm0_stb_i,
    input  logic              wbm0_cyc_i,
    output logic [XLEN-1:0]   wbm0_dat_o,
    output logic              wbm0_ack_o,
    output logic              wbm0_err_o,
    output logic              wbm0_rty_o,

    input  logic [XLEN-1:0]   wbm1_adr_i,
    input  logic [XLEN-1:0]   wbm1_dat_i,
    input  logic [XLEN/8-1:0] wbm1_sel_i,
    input  logic              wbm1_we_i,
    input  logic              wbm1_stb_i,
    input  logic              wbm1_cyc_i,
    output logic [XLEN-1:0]   wbm1_dat_o,
    output logic              wbm1_ack_o,
    output logic              wbm1_err_o,
    output logic              wbm1_rty_o,

    output logic [XLEN-1:0]   wbs_adr_o,
    output logic [XLEN-1:0]   wbs_dat_o,
    output logic [XLEN/8-1:0] wbs_sel_o,
    output logic              wbs_we_o,
    output logic              wbs_stb_o,
    output logic              wbs_cyc_o,
    input  logic [XLEN-1:0]   wbs_dat_i,
    input  logic              wbs_ack_i,
    input  logic              wbs_err_i,
    input  logic              wbs_rty_i,

    output logic              timeout_o
);

    arb_state_t state;
    logic       last_gnt;
    logic       abort;

    logic gnt0, gnt1, granted, live, resp_any;
    logic m_cyc, m_stb;
    logic wd_en, wd_clr, expired;

    assign gnt0    = (state == GNT0);
    assign gnt1    = (state == GNT1);
    assign granted = gnt0 || gnt1;

    assign m_cyc = gnt1 ? wbm1_cyc_i : wbm0_cyc_i;
    assign m_stb = gnt1 ? wbm1_stb_i : wbm0_stb_i;

    assign wbs_adr_o = gnt1 ? wbm1_adr_i : wbm0_adr_i;
    assign wbs_dat_o = gnt1 ? wbm1_dat_i : wbm0_dat_i;
    assign wbs_sel_o = gnt1 ? wbm1_sel_i : wbm0_sel_i;
    assign wbs_we_o  = gnt1 ? wbm1_we_i  : wbm0_we_i;
    assign wbs_cyc_o = granted && !abort && m_cyc;
    assign wbs_stb_o = granted && !abort && m_cyc && m_stb;

    // Responses reach a master only while its cycle is live; anything the
    // slave returns in IDLE, during an abort or under reset is dropped.
    assign live     = granted && !abort && !rst;
    assign resp_any = wbs_ack_i || wbs_err_i || wbs_rty_i;

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    assign wbm0_ack_o = live && gnt0 && wbs_ack_i;
    assign wbm0_rty_o = live && gnt0 && wbs_rty_i;
    assign wbm0_err_o = live && gnt0 && (wbs_err_i || expired);
    assign wbm1_ack_o = live && gnt1 && wbs_ack_i;
    assign wbm1_rty_o = live && gnt1 && wbs_rty_i;
    assign wbm1_err_o = live && gnt1 && (wbs_err_i || expired);
    assign timeout_o  = expired && !rst;

    // The abort only reaches wbs_cyc_o/stb_o through the registered abort
    // flag, keeping the slave response out of every wbs_* output path.
    assign wd_en  = wbs_stb_o && !resp_any;
    assign wd_clr = !granted || resp_any || expired;

    mr_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
            abort    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (wbm0_cyc_i && wbm1_cyc_i) begin
                        state <= last_gnt ? GNT0 : GNT1;
                    end else if (wbm0_cyc_i) begin
                        state <= GNT0;
                    end else if (wbm1_cyc_i) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!wbm0_cyc_i) begin
                        state    <= IDLE;
                        last_gnt <= 1'b0;
                        abort    <= 1'b0;
                    end else if (expired) begin
                        abort <= 1'b1;
                    end
                end
                GNT1: begin
                    if (!wbm1_cyc_i) begin
                        state    <= IDLE;
                        last_gnt <= 1'b1;
                        abort    <= 1'b0;
                    end else if (expired) begin
                        abort <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    abort <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mr_bus_arb.sv
// Directed bench for mr_bus_arb (TIMEOUT=4): grant latency, round robin,
// bus lock, watchdog abort, ack-beats-timeout, and mid-transaction reset.
module tb_mr_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbm0_adr_i, wbm0_dat_i, wbm0_dat_o;
    logic [3:0]  wbm0_sel_i;
    logic        wbm0_we_i, wbm0_stb_i, wbm0_cyc_i;
    logic        wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
    logic [31:0] wbm1_adr_i, wbm1_dat_i, wbm1_dat_o;
    logic [3:0]  wbm1_sel_i;
    logic        wbm1_we_i, wbm1_stb_i, wbm1_cyc_i;
    logic        wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
    logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mr_bus_arb #(
        .TIMEOUT (4),
        .XLEN    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wbm0_adr_i (wbm0_adr_i),
        .wbm0_dat_i (wbm0_dat_i),
        .wbm0_sel_i (wbm0_sel_i),
        .wbm0_we_i  (wbm0_we_i),
        .wbm0_stb_i (wbm0_stb_i),
        .wbm0_cyc_i (wbm0_cyc_i),
        .wbm0_dat_o (wbm0_dat_o),
        .wbm0_ack_o (wbm0_ack_o),
        .wbm0_err_o (wbm0_err_o),
        .wbm0_rty_o (wbm0_rty_o),
        .wbm1_adr_i (wbm1_adr_i),
        .wbm1_dat_i (wbm1_dat_i),
        .wbm1_sel_i (wbm1_sel_i),
        .wbm1_we_i  (wbm1_we_i),
        .wbm1_stb_i (wbm1_stb_i),
        .wbm1_cyc_i (wbm1_cyc_i),
        .wbm1_dat_o (wbm1_dat_o),
        .wbm1_ack_o (wbm1_ack_o),
        .wbm1_err_o (wbm1_err_o),
        .wbm1_rty_o (wbm1_rty_o),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_i  (wbs_ack_i),
        .wbs_err_i  (wbs_err_i),
        .wbs_rty_i  (wbs_rty_i),
        .timeout_o  (timeout_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        wbm0_adr_i = '0; wbm0_dat_i = '0; wbm0_sel_i = '0;
        wbm0_we_i = 1'b0; wbm0_stb_i = 1'b0; wbm0_cyc_i = 1'b0;
        wbm1_adr_i = '0; wbm1_dat_i = '0; wbm1_sel_i = '0;
        wbm1_we_i = 1'b0; wbm1_stb_i = 1'b0; wbm1_cyc_i = 1'b0;
        wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state and data fan-out
        wbs_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("rst_cyc", 32'(wbs_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbs_stb_o), 32'd0);
        chk("rst_resp", 32'({wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o}), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("dat_fan0", wbm0_dat_o, 32'hDEAD_BEEF);
        chk("dat_fan1", wbm1_dat_o, 32'hDEAD_BEEF);

        // m0 single access: grant at N+1, ack to m0 only
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h100;
        wbm0_dat_i = 32'h55; wbm0_we_i = 1'b1; wbm0_sel_i = 4'hF;
        #1;
        chk("lat_n_cyc", 32'(wbs_cyc_o), 32'd0);
        step();
        chk("lat_n1_cyc", 32'(wbs_cyc_o), 32'd1);
        chk("m0_adr", wbs_adr_o, 32'h100);
        chk("m0_dat", wbs_dat_o, 32'h55);
        chk("m0_we_sel", 32'({wbs_we_o, wbs_sel_o}), 32'h1F);
        wbs_ack_i = 1'b1;
        #1;
        chk("m0_ack", 32'({wbm0_ack_o, wbm1_ack_o}), 32'b10);
        step();
        wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        step();
        chk("m0_done_idle", 32'(wbs_cyc_o), 32'd0);

        // Tie after reset goes to m1; m0 follows after one dead cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h200; wbm0_we_i = 1'b0;
        wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; wbm1_adr_i = 32'h300;
        step();
        chk("tie_m1_adr", wbs_adr_o, 32'h300);
        wbs_ack_i = 1'b1;
        #1;
        chk("tie_m1_ack", 32'({wbm0_ack_o, wbm1_ack_o}), 32'b01);
        step();
        wbs_ack_i = 1'b0; wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
        step();
        chk("tie_dead_cyc", 32'(wbs_cyc_o), 32'd0);
        step();
        chk("tie_m0_cyc", 32'(wbs_cyc_o), 32'd1);
        chk("tie_m0_adr", wbs_adr_o, 32'h200);
        wbs_ack_i = 1'b1;
        step();
        wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        step();

        // Bus lock: m1 keeps the grant across three strobes
        wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; wbm1_adr_i = 32'h400;
        step();
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h500;
        for (int i = 0; i < 3; i++) begin
            wbm1_adr_i = 32'h400 + 32'(4 * i);
            wbs_ack_i = 1'b1;
            #1;
            chk("lock_adr", wbs_adr_o, 32'h400 + 32'(4 * i));
            chk("lock_ack", 32'({wbm0_ack_o, wbm1_ack_o}), 32'b01);
            step();
            wbs_ack_i = 1'b0;
        end
        wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
        step();
        chk("lock_dead_cyc", 32'(wbs_cyc_o), 32'd0);
        step();
        chk("lock_m0_adr", wbs_adr_o, 32'h500);
        chk("lock_m0_cyc", 32'(wbs_cyc_o), 32'd1);
        wbs_ack_i = 1'b1;
        step();
        wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        step();

        // Watchdog abort on the 4th stalled cycle
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h600;
        step();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("wd_stall_err", 32'({wbm0_err_o, timeout_o, wbs_cyc_o}), 32'b001);
            step();
        end
        #1;
        chk("wd_abort", 32'({wbm0_err_o, wbm1_err_o, timeout_o}), 32'b101);
        step();
        chk("wd_held_cyc", 32'({wbs_cyc_o, wbs_stb_o}), 32'd0);
        chk("wd_pulse_end", 32'({wbm0_err_o, timeout_o}), 32'd0);
        wbs_ack_i = 1'b1;
        #1;
        chk("wd_ack_drop", 32'(wbm0_ack_o), 32'd0);
        step();
        wbs_ack_i = 1'b0;
        chk("wd_held_cyc2", 32'(wbs_cyc_o), 32'd0);
        wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        step();
        chk("wd_idle_cyc", 32'(wbs_cyc_o), 32'd0);

        // Ack on the 4th stalled cycle wins over the timeout
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h700;
        step();
        chk("race_cyc", 32'(wbs_cyc_o), 32'd1);
        step(); step(); step();
        wbs_ack_i = 1'b1;
        #1;
        chk("race_ack", 32'({wbm0_ack_o, wbm0_err_o, timeout_o}), 32'b100);
        step();
        wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        #1;
        chk("race_after", 32'({wbm0_err_o, timeout_o}), 32'd0);
        step();

        // Reset while m1 is mid-strobe
        wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; wbm1_adr_i = 32'h800;
        step();
        chk("mrst_pre_cyc", 32'(wbs_cyc_o), 32'd1);
        chk("mrst_pre_adr", wbs_adr_o, 32'h800);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wbs_ack_i = 1'b1;
        #1;
        chk("mrst_cyc", 32'({wbs_cyc_o, wbs_stb_o}), 32'd0);
        chk("mrst_resp", 32'({wbm1_ack_o, wbm1_err_o, timeout_o}), 32'd0);
        step();
        wbs_ack_i = 1'b0;
        chk("mrst_regrant", 32'(wbs_cyc_o), 32'd1);
        wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mr_bus_arb.md
MR_BUS_ARB -- requirements
Module: mr_bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the number of stalled strobe cycles before watchdog abort (range 1..255).
REQ-002 Parameter XLEN, default `XLEN from config, SHALL set address and data width.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wbm0_{adr_i,dat_i} in XLEN, wbm0_sel_i in XLEN/8, wbm0_{we_i,stb_i,cyc_i} in 1  instruction-fetch master request.
REQ-006 wbm0_dat_o out XLEN, wbm0_{ack_o,err_o,rty_o} out 1  instruction-fetch master response.
REQ-007 wbm1_* SHALL mirror wbm0_* exactly, for the load-store master.
REQ-008 wbs_{adr_o,dat_o} out XLEN, wbs_sel_o out XLEN/8, wbs_{we_o,stb_o,cyc_o} out 1  shared slave request.
REQ-009 wbs_dat_i in XLEN, wbs_{ack_i,err_i,rty_i} in 1  shared slave response.
REQ-010 timeout_o out 1  one-cycle pulse when the watchdog aborts a cycle.

Function
REQ-011 FSM states SHALL be IDLE, GNT0, GNT1; state and last-grant bit SHALL be registered.
REQ-012 IDLE, exactly one cyc_i high: next state SHALL be that master's GNT state.
REQ-013 IDLE, both cyc_i high: grant SHALL go to the master not granted last (round robin).
REQ-014 IDLE, no cyc_i: SHALL remain IDLE; wbs_cyc_o and wbs_stb_o SHALL be 0.
REQ-015 GNTx: wbs_adr_o/dat_o/sel_o/we_o/stb_o/cyc_o SHALL be combinationally muxed from master x.
REQ-016 GNTx: ack/err/rty SHALL route only to master x; the other master's ack/err/rty SHALL be 0.
REQ-017 Both wbmN_dat_o SHALL be driven from wbs_dat_i at all times.
REQ-018 GNTx with wbmx_cyc_i low: next state SHALL be IDLE, giving exactly one dead cycle between grants; last-grant SHALL update to x.
REQ-019 A granted master holding cyc_i across multiple strobes SHALL keep the grant (bus lock); no preemption.
REQ-020 Arbitration latency: cyc_i high in IDLE at cycle N SHALL give wbs_cyc_o high at cycle N+1.
REQ-021 Watchdog counter SHALL increment each GNT cycle with wbs_stb_o=1 and no ack/err/rty, and SHALL clear on any response or on leaving GNT.
REQ-022 When the counter equals TIMEOUT, the arbiter SHALL assert wbmx_err_o and timeout_o for one cycle, force wbs_cyc_o/stb_o to 0, and hold them at 0 until master x drops cyc_i.
REQ-023 A slave ack arriving in the same cycle the counter reaches TIMEOUT SHALL take precedence: ack passes, no abort.
REQ-024 Slave responses arriving while IDLE or during an abort SHALL be discarded.

Reset
REQ-025 In the cycle after rst is sampled high: state IDLE, last-grant 0 (so master 1 wins the first tie), counter 0, abort flag 0.
REQ-026 While in IDLE after reset, wbs_cyc_o, wbs_stb_o, all wbmN_ack_o/err_o/rty_o and timeout_o SHALL read 0.
REQ-027 A reset mid-transaction SHALL drop wbs_cyc_o/stb_o in the cycle after rst is sampled, with no response issued to the master.

Structure
REQ-028 The state enum (IDLE/GNT0/GNT1) SHALL live in shared package mr_pkg; XLEN SHALL come from config.svi.
REQ-029 The watchdog counter SHALL be a sub-module, mr_arb_watchdog (inputs clk, rst, en, clr; output expired).
REQ-030 Implementation SHALL be synthesizable, with no latches and no combinational path from wbs_ack_i to any wbs_* output.

Verification
REQ-031 Reset, then m0 cyc/stb, adr 0x100 -> wbs_cyc_o at N+1, wbs_adr_o=0x100, ack routed to m0 only.
REQ-032 Both masters request together after reset -> m1 granted; m1 drops cyc -> one IDLE cycle -> m0 granted.
REQ-033 m1 holds cyc for 3 back-to-back strobes while m0 waits -> m1 keeps grant for all 3; m0 granted after m1 drops cyc plus one cycle.
REQ-034 TIMEOUT=4, slave never acks -> wbm0_err_o and timeout_o pulse on 4th stalled cycle; wbs_cyc_o=0 until m0 drops cyc.
REQ-035 TIMEOUT=4, ack on the 4th stalled cycle -> ack passes, no err, no timeout_o.
REQ-036 rst asserted while GNT1 is mid-strobe -> next cycle state IDLE, wbs_cyc_o=0, no ack/err to m1.
